// File: rtl/dwa_sel16_if.sv
// Sample/result bundle for the 16-element dual-bank DWA selector.
// en is a one-cycle sample strobe with no back-pressure; vld pulses once per accepted sample.
interface dwa_sel16_if;
    logic        en;
    logic [3:0]  Gama;
    logic [3:0]  Beta;
    logic        dwa_en;
    logic [15:0] sel;
    logic        vld;
    logic        sat;
    logic [4:0]  sel_cnt;
    logic [2:0]  ptr_a;
    logic [2:0]  ptr_b;

    modport master (
        output en, Gama, Beta, dwa_en,
        input  sel, vld, sat, sel_cnt, ptr_a, ptr_b
    );

    modport slave (
        input  en, Gama, Beta, dwa_en,
        output sel, vld, sat, sel_cnt, ptr_a, ptr_b
    );
endinterface

// File: rtl/dwa_sel16.sv
// Two 8-element data-weighted-averaging selectors (bank A = sel[7:0], bank B = sel[15:8]).
// Every output is registered; counts above 8 clip to a full bank and raise sat.
module dwa_sel16 (
    input  logic         clk,
    input  logic         rst,
    dwa_sel16_if.slave   bus
);

    logic [3:0]  a_clip;
    logic [3:0]  b_clip;
    logic [7:0]  mask_a;
    logic [7:0]  mask_b;
    logic [2:0]  rot_a;
    logic [2:0]  rot_b;
    logic [15:0] sel_next;
    logic [2:0]  ptr_a_next;
    logic [2:0]  ptr_b_next;
    logic [4:0]  cnt_next;
    logic        sat_next;

    function automatic logic [7:0] therm8(input logic [3:0] n);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            t[i] = (4'(i) < n);
        end
        return t;
    endfunction

    // Rotate left within the bank: the upper byte of the doubled mask wraps naturally.
    function automatic logic [7:0] rotl8(input logic [7:0] m, input logic [2:0] p);
        logic [15:0] dbl;
        dbl = {m, m} << p;
        return dbl[15:8];
    endfunction

    always_comb begin
        a_clip     = (bus.Gama > 4'd8) ? 4'd8 : bus.Gama;
        b_clip     = (bus.Beta > 4'd8) ? 4'd8 : bus.Beta;
        rot_a      = bus.dwa_en ? bus.ptr_a : 3'd0;
        rot_b      = bus.dwa_en ? bus.ptr_b : 3'd0;
        mask_a     = rotl8(therm8(a_clip), rot_a);
        mask_b     = rotl8(therm8(b_clip), rot_b);
        sel_next   = {mask_b, mask_a};
        // A full bank (count 8) adds 0 mod 8, so the pointer stays put.
        ptr_a_next = bus.dwa_en ? (bus.ptr_a + a_clip[2:0]) : 3'd0;
        ptr_b_next = bus.dwa_en ? (bus.ptr_b + b_clip[2:0]) : 3'd0;
        cnt_next   = {1'b0, a_clip} + {1'b0, b_clip};
        sat_next   = (bus.Gama > 4'd8) || (bus.Beta > 4'd8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sel     <= '0;
            bus.vld     <= 1'b0;
            bus.sat     <= 1'b0;
            bus.sel_cnt <= '0;
            bus.ptr_a   <= '0;
            bus.ptr_b   <= '0;
        end else begin
            bus.vld <= bus.en;
            if (bus.en) begin
                bus.sel     <= sel_next;
                bus.sat     <= sat_next;
                bus.sel_cnt <= cnt_next;
                bus.ptr_a   <= ptr_a_next;
                bus.ptr_b   <= ptr_b_next;
            end
        end
    end

endmodule
